muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Sequential multiply/divide unit with MIPS-style HI/LO results.
//            MULT/MULTU use radix-2 shift-add. DIV/DIVU use restoring
//            division, one bit per cycle. Both run on operand magnitudes and
//            fix the signs at the end. The last result stays on hi/lo until
//            the next operation completes.
// Ports    : clk         - clock, rising edge
//            rst         - asynchronous reset, active-low
//            start       - operation request, sampled only when idle
//            op          - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//            a, b        - multiplicand/dividend, multiplier/divisor
//            busy        - operation in flight (accept edge .. return to idle)
//            done        - one-cycle result-valid pulse
//            hi, lo      - product upper/lower half, or remainder/quotient
//            div_by_zero - divide with b == 0; held until the next accept
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;       // operand a; holds its magnitude after PREP
  logic [WIDTH-1:0]   b_q;       // operand b; holds its magnitude after PREP
  // Multiply: {partial product, multiplier bits not yet consumed}.
  // Divide: the low half shifts the dividend out and the quotient in.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;     // settled partial remainder, always < divisor
  logic               neg_lo_q;  // negate product / quotient
  logic               neg_hi_q;  // negate remainder
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Sign handling for the PREP step.
  logic             sgn_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  // One iteration of each algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   div_rem_d;
  logic [WIDTH-1:0]   div_quo_d;

  // Sign correction for the FIX step.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    sgn_op = ~op_q[0];
    a_neg  = sgn_op & a_q[WIDTH-1];
    b_neg  = sgn_op & b_q[WIDTH-1];
    // The most negative value maps to 2^(WIDTH-1), which is still correct
    // when read as an unsigned magnitude.
    a_abs  = a_neg ? -a_q : a_q;
    b_abs  = b_neg ? -b_q : b_q;

    // The extra top bit of the sum catches the carry, and the right shift
    // moves it into the accumulator.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step. A borrow (negative trial) keeps the shifted remainder.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_quo_d = {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            busy_q <= 1'b1;
            if (op[1] && (b == '0)) begin
              dz_q    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dz_q    <= 1'b0;
              state_q <= S_PREP;
            end
          end
        end
        S_PREP: begin
          a_q      <= a_abs;
          b_q      <= b_abs;
          // The quotient sign and the product sign use the same rule.
          neg_lo_q <= a_neg ^ b_neg;
          neg_hi_q <= a_neg & op_q[1];
          cnt_q    <= '0;
          rem_q    <= '0;
          // Multiply: multiplier in the low half, multiplicand stays in a_q.
          // Divide: dividend in the low half.
          acc_q    <= {{WIDTH{1'b0}}, (op_q[1] ? a_abs : b_abs)};
          state_q  <= S_RUN;
        end
        S_RUN: begin
          if (op_q[1]) begin
            acc_q <= {acc_q[2*WIDTH-1:WIDTH], div_quo_d};
            rem_q <= div_rem_d;
          end else begin
            acc_q <= mul_acc_d;
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          // A normal operation arrives here with done already set. The
          // divide-by-zero path arrives with done clear and raises it one
          // cycle later, so its pulse follows the edge after the accept.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Directed self-checking bench for muldiv_seq. It uses a 32-bit
//            and an 8-bit instance. Every expected value is a hand-computed
//            constant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst32, start32, busy32, done32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        rst8, start8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst32), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_by_zero(dz32)
  );

  muldiv_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation from an idle cycle and wait for done (bounded).
  // lat counts the edges after the accept edge until done is seen high:
  // WIDTH+2 for a normal operation and 1 for divide-by-zero. If poke is set,
  // start is driven with a different request while the 32-bit unit is busy.
  task automatic run_op(input string name, input bit w8, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input bit poke,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic rdz, output int lat);
    if (w8) begin
      op8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end else begin
      op32 = op; a32 = a; b32 = b; start32 = 1'b1;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    check($sformatf("%s.busy_accept", name), {63'd0, (w8 ? busy8 : busy32)}, 64'd1);
    lat = 0;
    if (poke) begin
      op32 = 2'b11; a32 = 32'h1; b32 = 32'h0; start32 = 1'b1;
    end
    while (((w8 ? done8 : done32) == 1'b0) && (lat < 200)) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) start32 = 1'b0;
    end
    start32 = 1'b0;
    rhi = w8 ? {24'h0, hi8} : hi32;
    rlo = w8 ? {24'h0, lo8} : lo32;
    rdz = w8 ? dz8 : dz32;
    @(posedge clk); #1;
    check($sformatf("%s.done_pulse", name), {63'd0, (w8 ? done8 : done32)}, 64'd0);
    check($sformatf("%s.busy_idle", name), {63'd0, (w8 ? busy8 : busy32)}, 64'd0);
  endtask

  task automatic do_vec(input string name, input bit w8, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input bit poke,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz, input int exp_lat);
    logic [31:0] rhi, rlo;
    logic        rdz;
    int          lat;
    run_op(name, w8, op, a, b, poke, rhi, rlo, rdz, lat);
    check($sformatf("%s.hi", name), {32'd0, rhi}, {32'd0, exp_hi});
    check($sformatf("%s.lo", name), {32'd0, rlo}, {32'd0, exp_lo});
    check($sformatf("%s.dz", name), {63'd0, rdz}, {63'd0, exp_dz});
    check($sformatf("%s.latency", name), 64'(lat), 64'(exp_lat));
  endtask

  // Safety net in case the bench itself stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone;
    rst32 = 1'b0; start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    rst8  = 1'b0; start8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0;
    #12;
    check("rst.busy32", {63'd0, busy32}, 64'd0);
    check("rst.done32", {63'd0, done32}, 64'd0);
    check("rst.hi32",   {32'd0, hi32},   64'd0);
    check("rst.lo32",   {32'd0, lo32},   64'd0);
    check("rst.dz32",   {63'd0, dz32},   64'd0);
    check("rst.busy8",  {63'd0, busy8},  64'd0);
    check("rst.hilo8",  {48'd0, hi8, lo8}, 64'd0);
    @(negedge clk);
    rst32 = 1'b1; rst8 = 1'b1;
    @(posedge clk); #1;

    // 32-bit vectors. Done is high in the cycle ending at accept+35.
    do_vec("mult_7_m3",   1'b0, 2'b00, 32'd7,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    do_vec("multu_max",   1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
    do_vec("div_m7_2",    1'b0, 2'b10, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    do_vec("div_min_m1",  1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 1'b0, 34);
    do_vec("mult_min_sq", 1'b0, 2'b00, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 1'b0, 34);
    do_vec("div_7_m2",    1'b0, 2'b10, 32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34);
    do_vec("divu_100_7",  1'b0, 2'b11, 32'd100,      32'd7,        1'b0, 32'h00000002, 32'h0000000E, 1'b0, 34);
    // Divide by zero keeps the previous hi/lo and flags the error.
    do_vec("divu_by0",    1'b0, 2'b11, 32'd5,        32'd0,        1'b0, 32'h00000002, 32'h0000000E, 1'b1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("by0.dz_held", {63'd0, dz32}, 64'd1);

    // Apply reset asynchronously in the middle of a multiply.
    op32 = 2'b00; a32 = 32'd7; b32 = 32'd9; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("midrst.dz_clear_on_accept", {63'd0, dz32}, 64'd0);
    repeat (11) @(posedge clk);  // RUN iteration 10 is now in progress
    #3;
    rst32 = 1'b0;
    #1;
    check("midrst.busy", {63'd0, busy32}, 64'd0);
    check("midrst.done", {63'd0, done32}, 64'd0);
    check("midrst.hi",   {32'd0, hi32},   64'd0);
    check("midrst.lo",   {32'd0, lo32},   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst32 = 1'b1;
    ndone = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    check("midrst.no_done", 64'(ndone), 64'd0);
    do_vec("mult_3_5",    1'b0, 2'b00, 32'd3,        32'd5,        1'b0, 32'h00000000, 32'h0000000F, 1'b0, 34);

    // 8-bit vectors. Done is high in the cycle ending at accept+11.
    do_vec("w8_mult_80sq", 1'b1, 2'b00, 32'h80, 32'h80, 1'b0, 32'h40, 32'h00, 1'b0, 10);
    do_vec("w8_div_m7_2",  1'b1, 2'b10, 32'hF9, 32'h02, 1'b0, 32'hFF, 32'hFD, 1'b0, 10);
    do_vec("w8_divu_ff10", 1'b1, 2'b11, 32'hFF, 32'h10, 1'b0, 32'h0F, 32'h0F, 1'b0, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
